// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB round-robin arbiter.
// Transfer encodings and arbiter FSM states.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate, lowest-bit priority, rotate back.
// Search starts at ptr and wraps modulo MANAGERS.
module rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int MANAGERS = 4
) (
  input  logic [MANAGERS-1:0]         req,
  input  logic [$clog2(MANAGERS)-1:0] ptr,
  output logic [MANAGERS-1:0]         onehot,
  output logic [$clog2(MANAGERS)-1:0] idx,
  output logic                        any
);

  localparam int IW = $clog2(MANAGERS);

  logic [2*MANAGERS-1:0] dbl_req;
  logic [2*MANAGERS-1:0] dbl_oh;
  logic [MANAGERS-1:0]   rot;
  logic [MANAGERS-1:0]   rot_oh;

  // ptr < MANAGERS, so a doubled vector gives an exact modulo rotate
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot     = dbl_req[MANAGERS-1:0];
    rot_oh  = rot & (-rot);
    dbl_oh  = {rot_oh, rot_oh} << ptr;
    onehot  = dbl_oh[2*MANAGERS-1:MANAGERS];
    any     = |req;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < MANAGERS; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin arbiter with burst/lock hold and tenure cap.
// Define ARB_PARK_EN to park the grant on DEFAULT_MGR when idle.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MANAGERS    = 4,
  parameter int MAX_HOLD    = 16,
  parameter int DEFAULT_MGR = 0
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [MANAGERS-1:0]         req_i,
  input  logic [MANAGERS-1:0]         lock_i,
  input  logic [1:0]                  htrans_i,
  input  logic                        hready_i,
  output logic [MANAGERS-1:0]         grant_o,
  output logic [$clog2(MANAGERS)-1:0] grant_id_o,
  output logic                        grant_valid_o,
  output logic                        handover_o
);

  localparam int IW = $clog2(MANAGERS);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

`ifdef ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  localparam logic [MANAGERS-1:0] ONE      = MANAGERS'(1);
  localparam logic [MANAGERS-1:0] PARK_OH  = PARK ? (ONE << DEFAULT_MGR) : '0;
  localparam logic [IW-1:0]       PARK_ID  = PARK ? IW'(DEFAULT_MGR) : '0;
  localparam logic [IW-1:0]       LAST     = IW'(MANAGERS - 1);
  localparam logic [HW-1:0]       HOLD_SAT = HW'(MAX_HOLD);
  localparam logic [HW-1:0]       HOLD_CAP =
    HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t          state_q, state_d;
  logic [MANAGERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]       id_q, id_d;
  logic                vld_q, vld_d;
  logic                ho_q, ho_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic [MANAGERS-1:0] w_oh;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [IW-1:0]       ptr_nxt;
  logic [HW-1:0]       hold_nxt;
  logic                b_idle, b_own;
  logic                others, own_req, cap;
  logic                take, rel;

  rr_pick #(
    .MANAGERS (MANAGERS)
  ) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .onehot (w_oh),
    .idx    (w_idx),
    .any    (w_any)
  );

  always_comb begin
    ptr_nxt  = (w_idx == LAST) ? '0 : w_idx + IW'(1);
    hold_nxt = hold_q;
    if ((MAX_HOLD != 0) && hready_i && (hold_q != HOLD_SAT))
      hold_nxt = hold_q + HW'(1);
    cap     = (MAX_HOLD != 0) && (hold_q >= HOLD_CAP);
    b_idle  = hready_i && (htrans_i != SEQ);
    b_own   = b_idle && !lock_i[id_q];
    others  = |(req_i & ~gnt_q);
    own_req = |(req_i & gnt_q);
    take    = 1'b0;
    rel     = 1'b0;
    if (state_q == ARB_IDLE) begin
      take = b_idle && w_any;
    end else begin
      take = b_own && others && (!own_req || cap);
      rel  = b_own && !w_any;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    ho_d    = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (1'b1)
      take: begin
        state_d = ARB_OWN;
        gnt_d   = w_oh;
        id_d    = w_idx;
        vld_d   = 1'b1;
        ptr_d   = ptr_nxt;
        hold_d  = '0;
        // leaving park to the parked manager is not an ownership change
        ho_d    = (state_q == ARB_OWN) || !PARK ||
                  (w_idx != PARK_ID);
      end
      rel: begin
        state_d = ARB_IDLE;
        gnt_d   = PARK_OH;
        id_d    = PARK_ID;
        vld_d   = PARK;
        hold_d  = '0;
      end
      default: begin
        if (state_q == ARB_OWN) hold_d = hold_nxt;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= PARK_OH;
      id_q    <= PARK_ID;
      vld_q   <= PARK;
      ho_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      ho_q    <= ho_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_o       = gnt_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = vld_q;
  assign handover_o    = ho_q;

endmodule
